// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith/move results plus a
// 32-step restoring divider that stalls the front end and writes HI/LO.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 6;
  localparam int unsigned OPW  = 8;
  localparam int unsigned SELW = 3;

  localparam logic [SELW-1:0] SEL_NOP   = 3'b000;
  localparam logic [SELW-1:0] SEL_LOGIC = 3'b001;
  localparam logic [SELW-1:0] SEL_SHIFT = 3'b010;
  localparam logic [SELW-1:0] SEL_MOVE  = 3'b011;
  localparam logic [SELW-1:0] SEL_ARITH = 3'b100;

  localparam logic [OPW-1:0] OP_AND  = 8'h24;
  localparam logic [OPW-1:0] OP_OR   = 8'h25;
  localparam logic [OPW-1:0] OP_XOR  = 8'h26;
  localparam logic [OPW-1:0] OP_NOR  = 8'h27;
  localparam logic [OPW-1:0] OP_SLL  = 8'h7C;
  localparam logic [OPW-1:0] OP_SRL  = 8'h02;
  localparam logic [OPW-1:0] OP_SRA  = 8'h03;
  localparam logic [OPW-1:0] OP_ADDU = 8'h21;
  localparam logic [OPW-1:0] OP_SUBU = 8'h23;
  localparam logic [OPW-1:0] OP_SLT  = 8'h2A;
  localparam logic [OPW-1:0] OP_MFHI = 8'h10;
  localparam logic [OPW-1:0] OP_MFLO = 8'h12;
  localparam logic [OPW-1:0] OP_DIV  = 8'h1A;
  localparam logic [OPW-1:0] OP_DIVU = 8'h1B;

  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  div_state_t      r_state;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_divisor;
  logic [DW-1:0]   r_quot;
  logic [DW-1:0]   r_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;

  logic [4:0]      w_shamt;
  logic [DW-1:0]   w_logic_res;
  logic [DW-1:0]   w_shift_res;
  logic [DW-1:0]   w_arith_res;
  logic [DW-1:0]   w_move_res;
  logic [DW-1:0]   w_result;
  logic            w_is_div;
  logic            w_signed_div;
  logic [DW-1:0]   w_abs_a;
  logic [DW-1:0]   w_abs_b;
  logic [DW:0]     w_shift_rem;
  logic [DW:0]     w_trial;
  logic [DW-1:0]   w_quot_fix;
  logic [DW-1:0]   w_rem_fix;

  assign w_shamt = reg2_i[4:0];

  always_comb begin
    w_logic_res = '0;
    case (aluop_i)
      OP_AND:  w_logic_res = reg1_i & reg2_i;
      OP_OR:   w_logic_res = reg1_i | reg2_i;
      OP_XOR:  w_logic_res = reg1_i ^ reg2_i;
      OP_NOR:  w_logic_res = ~(reg1_i | reg2_i);
      default: w_logic_res = '0;
    endcase
  end

  always_comb begin
    w_shift_res = '0;
    case (aluop_i)
      OP_SLL:  w_shift_res = reg1_i << w_shamt;
      OP_SRL:  w_shift_res = reg1_i >> w_shamt;
      OP_SRA:  w_shift_res = DW'($signed(reg1_i) >>> w_shamt);
      default: w_shift_res = '0;
    endcase
  end

  always_comb begin
    w_arith_res = '0;
    case (aluop_i)
      OP_ADDU: w_arith_res = reg1_i + reg2_i;
      OP_SUBU: w_arith_res = reg1_i - reg2_i;
      OP_SLT:  w_arith_res = {{(DW-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      default: w_arith_res = '0;
    endcase
  end

  always_comb begin
    w_move_res = '0;
    case (aluop_i)
      OP_MFHI: w_move_res = r_hi;
      OP_MFLO: w_move_res = r_lo;
      default: w_move_res = '0;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (alusel_i)
      SEL_LOGIC: w_result = w_logic_res;
      SEL_SHIFT: w_result = w_shift_res;
      SEL_ARITH: w_result = w_arith_res;
      SEL_MOVE:  w_result = w_move_res;
      default:   w_result = '0;
    endcase
  end

  assign w_is_div     = (alusel_i == SEL_NOP) && ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU));
  assign w_signed_div = (aluop_i == OP_DIV);

  // Divider works on magnitudes; signs are restored when the result retires.
  assign w_abs_a = (w_signed_div && reg1_i[DW-1]) ? (~reg1_i + DW'(1)) : reg1_i;
  assign w_abs_b = (w_signed_div && reg2_i[DW-1]) ? (~reg2_i + DW'(1)) : reg2_i;

  assign w_shift_rem = {r_rem, r_quot[DW-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_divisor};

  assign w_quot_fix = r_neg_q ? (~r_quot + DW'(1)) : r_quot;
  assign w_rem_fix  = r_neg_r ? (~r_rem + DW'(1)) : r_rem;

  // Divider FSM and HI/LO; r_quot doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_divisor <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            if (reg2_i == '0) begin
              r_quot  <= '1;
              r_rem   <= reg1_i;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_quot    <= w_abs_a;
              r_rem     <= '0;
              r_divisor <= w_abs_b;
              r_neg_q   <= w_signed_div && (reg1_i[DW-1] ^ reg2_i[DW-1]);
              r_neg_r   <= w_signed_div && reg1_i[DW-1];
              r_cnt     <= '0;
              r_state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (!w_trial[DW]) begin
            r_rem  <= w_trial[DW-1:0];
            r_quot <= {r_quot[DW-2:0], 1'b1};
          end else begin
            r_rem  <= w_shift_rem[DW-1:0];
            r_quot <= {r_quot[DW-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_hi    <= w_rem_fix;
          r_lo    <= w_quot_fix;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Issue cycle stalls combinationally so the front end freezes immediately.
  assign stallreq_o = !rst && (((r_state == S_IDLE) && w_is_div) || (r_state == S_BUSY));
  assign wd_o       = rst ? '0 : wd_i;
  assign wreg_o     = rst ? 1'b0 : (wreg_i && !w_is_div);
  assign wdata_o    = rst ? '0 : w_result;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: ALU ops against a reference model,
// divide latency/results, divide-by-zero and reset during a division.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [4:0]  wd;
  logic        wreg;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  wd;
    logic        wreg;
    int          stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] ops  [10] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h21, 8'h23, 8'h2A};
  logic [2:0] sels [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    if (sel == 3'b001) begin
      if (op == 8'h24) r = a & b;
      if (op == 8'h25) r = a | b;
      if (op == 8'h26) r = a ^ b;
      if (op == 8'h27) r = ~(a | b);
    end else if (sel == 3'b010) begin
      if (op == 8'h7C) r = a << b[4:0];
      if (op == 8'h02) r = a >> b[4:0];
      if (op == 8'h03) r = 32'($signed(a) >>> b[4:0]);
    end else if (sel == 3'b100) begin
      if (op == 8'h21) r = a + b;
      if (op == 8'h23) r = a - b;
      if (op == 8'h2A) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    end
    return r;
  endfunction

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w,
                       input logic [31:0] exp_data, input int exp_stall);
    exp_t e;
    aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = w;
    e.data  = exp_data;
    e.wd    = d;
    e.wreg  = w && !((sel == 3'b000) && ((op == 8'h1A) || (op == 8'h1B)));
    e.stall = exp_stall;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for the stall to drop, then retire one scoreboard entry.
  task automatic drain(input string tag);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (stallreq_o === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check({tag, ".data"},  wdata_o, e.data);
    check({tag, ".wd"},    32'(wd_o), 32'(e.wd));
    check({tag, ".wreg"},  32'(wreg_o), 32'(e.wreg));
    check({tag, ".stall"}, 32'(n), 32'(e.stall));
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string tag, input logic [7:0] o, input logic [2:0] sel,
                    input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                    input logic w, input logic [31:0] exp_data, input int exp_stall);
    drive(o, sel, a, b, d, w, exp_data, exp_stall);
    drain(tag);
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    logic signed [31:0] sa, sb;
    int k;

    rst = 1'b1;
    aluop = 8'h21; alusel = 3'b100; reg1 = 32'h1; reg2 = 32'h2; wd = 5'd5; wreg = 1'b1;
    @(negedge clk);
    check("rst.data", wdata_o, 32'h0);
    check("rst.wd", 32'(wd_o), 32'h0);
    check("rst.wreg", 32'(wreg_o), 32'h0);
    aluop = 8'h1B; alusel = 3'b000;
    @(negedge clk);
    check("rst.stall", 32'(stallreq_o), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    op("mfhi_rst", 8'h10, 3'b011, 32'h0, 32'h0, 5'd1, 1'b1, 32'h0, 0);
    op("addu_ovf", 8'h21, 3'b100, 32'h7FFFFFFF, 32'h1, 5'd5, 1'b1, 32'h80000000, 0);
    op("sra", 8'h03, 3'b010, 32'hF0000000, 32'd4, 5'd6, 1'b1, 32'hFF000000, 0);
    op("slt", 8'h2A, 3'b100, 32'hFFFFFFFF, 32'd1, 5'd7, 1'b1, 32'd1, 0);
    op("nop", 8'h00, 3'b000, 32'h1234, 32'h5678, 5'd0, 1'b0, 32'h0, 0);
    op("bad_op", 8'h55, 3'b001, 32'hFFFF, 32'hFFFF, 5'd9, 1'b1, 32'h0, 0);

    for (int i = 0; i < 20; i++) begin
      k = int'($urandom_range(0, 9));
      a = $urandom;
      b = $urandom;
      op("alu_rand", ops[k], sels[k], a, b, 5'(i), 1'b1, ref_alu(ops[k], sels[k], a, b), 0);
    end

    op("div_m7_2", 8'h1A, 3'b000, 32'hFFFFFFF9, 32'd2, 5'd3, 1'b1, 32'h0, 33);
    op("mflo_m7_2", 8'h12, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, 32'hFFFFFFFD, 0);
    op("mfhi_m7_2", 8'h10, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, 32'hFFFFFFFF, 0);

    op("divu_by0", 8'h1B, 3'b000, 32'd100, 32'd0, 5'd3, 1'b1, 32'h0, 1);
    op("mflo_by0", 8'h12, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, 32'hFFFFFFFF, 0);
    op("mfhi_by0", 8'h10, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, 32'd100, 0);

    // Reset after ten BUSY steps: stall drops, HI/LO cleared, not updated.
    aluop = 8'h1B; alusel = 3'b000; reg1 = 32'hFFFFFFFF; reg2 = 32'd7; wd = 5'd2; wreg = 1'b1;
    @(negedge clk);
    check("abort.issue_stall", 32'(stallreq_o), 32'h1);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort.stall", 32'(stallreq_o), 32'h0);
    check("abort.data", wdata_o, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    op("mfhi_abort", 8'h10, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0, 0);
    op("mflo_abort", 8'h12, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0, 0);

    op("divu_9_3", 8'h1B, 3'b000, 32'd9, 32'd3, 5'd3, 1'b1, 32'h0, 33);
    op("mflo_9_3", 8'h12, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, 32'd3, 0);
    op("mfhi_9_3", 8'h10, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, 32'd0, 0);

    op("div_ovf", 8'h1A, 3'b000, 32'h80000000, 32'hFFFFFFFF, 5'd3, 1'b1, 32'h0, 33);
    op("mflo_ovf", 8'h12, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, 32'h80000000, 0);
    op("mfhi_ovf", 8'h10, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0, 0);

    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = 32'($urandom_range(1, 100000));
      if (i[0]) begin
        if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
        sa = $signed(a);
        sb = $signed(b);
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
        op("div_rand", 8'h1A, 3'b000, a, b, 5'd3, 1'b1, 32'h0, 33);
      end else begin
        q = a / b;
        r = a % b;
        op("divu_rand", 8'h1B, 3'b000, a, b, 5'd3, 1'b1, 32'h0, 33);
      end
      op("mflo_rand", 8'h12, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, q, 0);
      op("mfhi_rand", 8'h10, 3'b011, 32'h0, 32'h0, 5'd4, 1'b1, r, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
